// File: rtl/mem_b_arbiter_if.sv
// Bundle of requester handshakes and memory port B signals shared by the
// port B arbiter and its environment.
interface mem_b_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    // Handshake: a requester raises rN_req with stable fields; the fields are
    // captured at the grant edge, rN_ready pulses for exactly one cycle when
    // the access is done (rN_rdata valid with it on a read), and req still
    // high in the next idle cycle starts a fresh transaction.
    logic          r0_req;
    logic          r0_we;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata;
    logic          r0_ready;
    logic [DW-1:0] r0_rdata;

    logic          r1_req;
    logic          r1_we;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata;
    logic          r1_ready;
    logic [DW-1:0] r1_rdata;

    logic [AW-1:0] mem_addr_b;
    logic          mem_we_b;
    logic [DW-1:0] mem_wdata_b;
    logic [DW-1:0] mem_rdata_b;
    logic [1:0]    gnt;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        output r0_ready, r0_rdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        output r1_ready, r1_rdata,
        output mem_addr_b, mem_we_b, mem_wdata_b,
        input  mem_rdata_b,
        output gnt
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        input  r0_ready, r0_rdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        input  r1_ready, r1_rdata,
        input  mem_addr_b, mem_we_b, mem_wdata_b,
        output mem_rdata_b,
        input  gnt
    );
endinterface

// File: rtl/mem_b_arbiter.sv
// Round-robin arbiter and access sequencer sharing memory port B between the
// CPU data path (requester 0) and the loader/debug master (requester 1).
module mem_b_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic             clk,
    input  logic             rst,
    mem_b_arbiter_if.slave   bus,
    output logic [1:0]       o_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_RC   = 2'd3
    } state_t;

    state_t        r_state, w_next;
    logic [1:0]    r_gnt, w_gnt_next;
    logic          r_last, w_last_next;
    logic [AW-1:0] r_addr, w_addr_next;
    logic [DW-1:0] r_wdata, w_wdata_next;
    logic          w_any;
    logic          w_sel1;
    logic          w_sel_we;
    logic          w_done;
    logic          w_rc;

    // r_last = 1 means requester 1 holds the most recent grant, so a tie goes to 0
    assign w_any    = bus.r0_req | bus.r1_req;
    assign w_sel1   = bus.r1_req & (~bus.r0_req | ~r_last);
    assign w_sel_we = w_sel1 ? bus.r1_we : bus.r0_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_gnt   <= 2'b00;
            r_last  <= 1'b1;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            r_gnt   <= w_gnt_next;
            r_last  <= w_last_next;
            r_addr  <= w_addr_next;
            r_wdata <= w_wdata_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_gnt_next   = r_gnt;
        w_last_next  = r_last;
        w_addr_next  = r_addr;
        w_wdata_next = r_wdata;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_gnt_next   = w_sel1 ? 2'b10 : 2'b01;
                    w_last_next  = w_sel1;
                    w_addr_next  = w_sel1 ? bus.r1_addr : bus.r0_addr;
                    w_wdata_next = w_sel1 ? bus.r1_wdata : bus.r0_wdata;
                    w_next       = w_sel_we ? S_WR : S_RD;
                end
            end
            S_WR: begin
                w_gnt_next = 2'b00;
                w_next     = S_IDLE;
            end
            S_RD: begin
                w_next = S_RC;
            end
            S_RC: begin
                w_gnt_next = 2'b00;
                w_next     = S_IDLE;
            end
            default: begin
                w_gnt_next = 2'b00;
                w_next     = S_IDLE;
            end
        endcase
    end

    // Write enable and ready decode straight from state so reset kills them at once
    assign w_done = (r_state == S_WR) || (r_state == S_RC);
    assign w_rc   = (r_state == S_RC);

    assign bus.mem_we_b    = (r_state == S_WR);
    assign bus.mem_addr_b  = r_addr;
    assign bus.mem_wdata_b = r_wdata;
    assign bus.gnt         = r_gnt;

    assign bus.r0_ready = w_done & r_gnt[0];
    assign bus.r1_ready = w_done & r_gnt[1];
    assign bus.r0_rdata = (w_rc && r_gnt[0]) ? bus.mem_rdata_b : '0;
    assign bus.r1_rdata = (w_rc && r_gnt[1]) ? bus.mem_rdata_b : '0;

    assign o_state = r_state;
endmodule

// File: tb/tb_mem_b_arbiter.sv
// Self-checking bench for mem_b_arbiter: directed scenarios followed by random
// transactions checked against a transaction-level arbitration/memory model.
module tb_mem_b_arbiter;
  logic       clk;
  logic       rst;
  logic       mem_clr;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int last_g   = 1;
  logic [7:0] ref_mem [256];
  logic [7:0] mem     [256];

  mem_b_arbiter_if #(.AW(8), .DW(8)) bus ();

  mem_b_arbiter #(.AW(8), .DW(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .o_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous-read memory behind port B
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (bus.mem_we_b) begin
      mem[bus.mem_addr_b] <= bus.mem_wdata_b;
    end
    bus.mem_rdata_b <= mem[bus.mem_addr_b];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input bit q0, input bit we0, input logic [7:0] a0, input logic [7:0] d0,
                       input bit q1, input bit we1, input logic [7:0] a1, input logic [7:0] d1);
    bus.r0_req = q0; bus.r0_we = we0; bus.r0_addr = a0; bus.r0_wdata = d0;
    bus.r1_req = q1; bus.r1_we = we1; bus.r1_addr = a1; bus.r1_wdata = d1;
  endtask

  // Called at the start of an idle cycle; runs one arbitration and its access.
  task automatic issue(input bit q0, input bit we0, input logic [7:0] a0, input logic [7:0] d0,
                       input bit q1, input bit we1, input logic [7:0] a1, input logic [7:0] d1,
                       input string tag);
    int w;
    bit we;
    logic [7:0] a, d;
    logic rdy_w, rdy_o;
    drive(q0, we0, a0, d0, q1, we1, a1, d1);
    if (!q0 && !q1) begin
      step();
      chk({tag, ".idle_gnt"}, 32'(bus.gnt), 32'd0);
      return;
    end
    w = (q0 && q1) ? 1 - last_g : (q0 ? 0 : 1);
    last_g = w;
    we = (w == 1) ? we1 : we0;
    a  = (w == 1) ? a1 : a0;
    d  = (w == 1) ? d1 : d0;
    step();
    rdy_w = (w == 1) ? bus.r1_ready : bus.r0_ready;
    rdy_o = (w == 1) ? bus.r0_ready : bus.r1_ready;
    chk({tag, ".gnt"}, 32'(bus.gnt), (w == 1) ? 32'd2 : 32'd1);
    chk({tag, ".addr"}, 32'(bus.mem_addr_b), 32'(a));
    chk({tag, ".we"}, 32'(bus.mem_we_b), 32'(we));
    chk({tag, ".rdy1"}, 32'(rdy_w), 32'(we));
    chk({tag, ".rdy_other1"}, 32'(rdy_o), 32'd0);
    // drop requests and disturb fields; the latched transaction must not change
    drive(1'b0, ~we0, a0 ^ 8'h10, ~d0, 1'b0, ~we1, a1 ^ 8'h10, ~d1);
    if (we) begin
      chk({tag, ".wdata"}, 32'(bus.mem_wdata_b), 32'(d));
      ref_mem[a] = d;
    end else begin
      step();
      rdy_w = (w == 1) ? bus.r1_ready : bus.r0_ready;
      rdy_o = (w == 1) ? bus.r0_ready : bus.r1_ready;
      chk({tag, ".gnt_hold"}, 32'(bus.gnt), (w == 1) ? 32'd2 : 32'd1);
      chk({tag, ".addr_hold"}, 32'(bus.mem_addr_b), 32'(a));
      chk({tag, ".rc_we"}, 32'(bus.mem_we_b), 32'd0);
      chk({tag, ".rdy2"}, 32'(rdy_w), 32'd1);
      chk({tag, ".rdy_other2"}, 32'(rdy_o), 32'd0);
      chk({tag, ".rdata"}, 32'((w == 1) ? bus.r1_rdata : bus.r0_rdata), 32'(ref_mem[a]));
      chk({tag, ".rdata_other"}, 32'((w == 1) ? bus.r0_rdata : bus.r1_rdata), 32'd0);
    end
    step();
    chk({tag, ".end_gnt"}, 32'(bus.gnt), 32'd0);
    chk({tag, ".end_rdy"}, 32'({bus.r1_ready, bus.r0_ready}), 32'd0);
    chk({tag, ".end_we"}, 32'(bus.mem_we_b), 32'd0);
  endtask

  initial begin
    int ng;
    int w;
    logic [1:0] prev;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

    // reset held with both requesters active
    rst = 1'b0;
    mem_clr = 1'b1;
    drive(1'b1, 1'b1, 8'h33, 8'h44, 1'b1, 1'b0, 8'h55, 8'h66);
    step(); step(); step();
    chk("rst.state", 32'(dbg_state), 32'd0);
    chk("rst.gnt", 32'(bus.gnt), 32'd0);
    chk("rst.we", 32'(bus.mem_we_b), 32'd0);
    chk("rst.addr", 32'(bus.mem_addr_b), 32'd0);
    chk("rst.wdata", 32'(bus.mem_wdata_b), 32'd0);
    chk("rst.ready", 32'({bus.r1_ready, bus.r0_ready}), 32'd0);
    chk("rst.rdata", 32'({bus.r1_rdata, bus.r0_rdata}), 32'd0);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    mem_clr = 1'b0;
    rst = 1'b1;

    // single write then read-back from requester 0
    issue(1'b1, 1'b1, 8'h10, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, "wr10");
    issue(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, "rd10");

    // field stability: r1 reads 0x20 while its address moves to 0x30
    issue(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h20, 8'h5C, "wr20");
    issue(1'b1, 1'b1, 8'h30, 8'hC3, 1'b0, 1'b0, 8'h00, 8'h00, "wr30");
    issue(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00, "rd20_stable");

    // early deassert: r0 read drops req during RD
    issue(1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, "rd30_early");

    // reset in the middle of a write
    issue(1'b1, 1'b1, 8'h40, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00, "wr40");
    drive(1'b1, 1'b1, 8'h40, 8'h77, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    chk("midrst.we_before", 32'(bus.mem_we_b), 32'd1);
    #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    chk("midrst.we", 32'(bus.mem_we_b), 32'd0);
    chk("midrst.ready", 32'(bus.r0_ready), 32'd0);
    chk("midrst.gnt", 32'(bus.gnt), 32'd0);
    chk("midrst.state", 32'(dbg_state), 32'd0);
    last_g = 1;
    step(); step();
    rst = 1'b1;

    // continuous contention: first tie after reset goes to r0, then strict alternation
    drive(1'b1, 1'b1, 8'h50, 8'h01, 1'b1, 1'b0, 8'h10, 8'h00);
    prev = 2'b00;
    ng = 0;
    for (int c = 0; c < 60 && ng < 6; c++) begin
      step();
      if (bus.r1_ready) chk("rr.r1_rdata", 32'(bus.r1_rdata), 32'(ref_mem[8'h10]));
      if (bus.gnt != 2'b00 && prev == 2'b00) begin
        w = 1 - last_g;
        last_g = w;
        chk("rr.order", 32'(bus.gnt), (w == 1) ? 32'd2 : 32'd1);
        if (w == 0) ref_mem[8'h50] = 8'h01;
        ng++;
      end
      prev = bus.gnt;
    end
    chk("rr.count", 32'(ng), 32'd6);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int c = 0; c < 5 && bus.gnt != 2'b00; c++) step();
    chk("rr.drain_state", 32'(dbg_state), 32'd0);

    // write cancelled by reset must not have landed
    issue(1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, "rd40_after_rst");
    issue(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h50, 8'h00, "rd50");

    // random traffic
    for (int k = 0; k < 60; k++) begin
      issue(($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 15)), 8'($urandom),
            ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 15)), 8'($urandom), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_b_arbiter.md
# mem_b_arbiter

Two-requester arbiter and sequencer for data port B of the dual-port `memory` block in the single-cycle CPU build. It shares the single read/write port between the CPU data path (requester 0) and an external loader/debug master (requester 1). It uses round-robin arbitration, a req/ready handshake, and a fixed multi-cycle access sequence. Port A (instruction fetch) is unaffected.

## Interface
- `AW`, 8, address width
- `DW`, 8, data width
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `r0_req` in 1: requester 0 transaction request.
- `r0_we` in 1: requester 0 direction (1 = write, 0 = read).
- `r0_addr` in AW: requester 0 address.
- `r0_wdata` in DW: requester 0 write data.
- `r0_ready` out 1: requester 0 transaction complete (one-cycle pulse).
- `r0_rdata` out DW: requester 0 read data; valid only while `r0_ready` is high on a read.
- `r1_req`, `r1_we`, `r1_addr`, `r1_wdata`, `r1_ready`, `r1_rdata`: same as the requester 0 ports, for requester 1.
- `mem_addr_b` out AW: memory port B address (registered).
- `mem_we_b` out 1: memory port B write enable.
- `mem_wdata_b` out DW: memory port B write data (registered).
- `mem_rdata_b` in DW: memory port B read data. Synchronous read: valid in the cycle after the address is presented.
- `gnt` out 2: one-hot current owner; `00` when idle.

## Operation
- FSM states are IDLE, WR, RD and RC. Reset state is IDLE.
- **IDLE**
  - Sample `r0_req` and `r1_req`.
  - If only one is high, that requester wins.
  - If both are high, the requester not granted last wins.
  - The winner's `addr`, `we` and `wdata` are latched into `mem_addr_b`/`mem_wdata_b` and an internal `we` flag.
  - `gnt` is set; next state is WR if `we`, else RD.
  - With no request, stay in IDLE.
- **WR**
  - `mem_we_b`=1 (combinational from state).
  - Owner's `ready`=1.
  - Go to IDLE.
- **RD**
  - `mem_we_b`=0; address is driven to the memory.
  - Go to RC.
- **RC**
  - Owner's `ready`=1; owner's `rdata` = `mem_rdata_b`.
  - Go to IDLE.
- **Last-grant pointer**
  - Updated when a grant is issued.
  - Reset value = requester 1, so requester 0 wins the first tie.
- **Request fields**
  - Sampled only at the grant edge. Changes during WR/RD/RC are ignored.
  - A requester deasserting `req` mid-transaction does not abort it; `ready` still pulses.
- **Handshake**
  - A transfer completes at the edge where `ready`=1.
  - `req` still high in the following IDLE cycle is a new transaction.
  - Non-owner `ready` is always 0 and its `rdata` is 0.

## Timing
- **Reset (async, immediate)**
  - State goes to IDLE.
  - `mem_addr_b`, `mem_wdata_b` = 0.
  - `mem_we_b` = 0, `gnt` = 00.
  - Both `ready` = 0, both `rdata` = 0.
  - Last-grant pointer = 1.
  - Any in-flight transaction is dropped with no `ready` pulse. A write in WR is cancelled within the same cycle.
- **Write latency:** request seen in IDLE cycle N → `mem_we_b` and `ready` high in cycle N+1 → IDLE in N+2.
- **Read latency:** request in cycle N → RD in N+1 → RC in N+2 with `ready` and `rdata`.
- **Back-to-back throughput:** one write per 2 cycles, one read per 3 cycles.
- **Contention:** with both requesting continuously, grants alternate strictly (0,1,0,1…) regardless of direction.
- `mem_we_b` is never high outside WR; `gnt` is held constant from the grant edge through the RC/WR cycle.

## Test plan
- **Reset:** hold `rst`=0 with both `req`=1 → all outputs at reset values, `mem_we_b`=0.
- **Single write:** release reset; r0 write addr 0x10, data 0xA5 → `mem_we_b`=1 and `r0_ready`=1 exactly one cycle later. A subsequent r0 read of 0x10 returns `r0_rdata`=0xA5 with `r0_ready` two cycles after grant.
- **Tie and round-robin:** both request simultaneously on the first arbitration after reset → r0 granted first (`gnt`=01), then r1 (`gnt`=10). Over 6 continuous requests, the grant order is 0,1,0,1,0,1.
- **Field stability:** r1 read 0x20 granted, then r1 changes addr to 0x30 during RD → memory sees 0x20, and returned data is from 0x20.
- **Mid-write reset:** assert `rst`=0 during WR for r0 write 0x40=0x77 → `mem_we_b` drops immediately, no `ready` pulse, FSM returns to IDLE.
- **Early deassert:** r0 drops `req` during RD → `r0_ready` still pulses in RC, then the FSM returns to IDLE with `gnt`=00.
